// File: rtl/mem2axi4_bridge.sv
// mem2axi4_bridge: single-outstanding bridge from the CPU load/store port to
// an AXI4 slave. Every CPU request becomes one single-beat AXI4 transaction.
// The response is checked, and cpu_done pulses for one cycle with the read
// data and the error flag.
module mem2axi4_bridge #(
    parameter int AXI4_ID_WIDTH = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // CPU side
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cpu_wstrb,
    output logic                      cpu_busy,
    output logic                      cpu_done,
    output logic [DATA_WIDTH-1:0]     cpu_rdata,
    output logic                      cpu_err,
    // AXI4 write address
    output logic [AXI4_ID_WIDTH-1:0]  M2_AXI4_AWID,
    output logic [ADDR_WIDTH-1:0]     M2_AXI4_AWADDR,
    output logic [7:0]                M2_AXI4_AWLEN,
    output logic [2:0]                M2_AXI4_AWSIZE,
    output logic [1:0]                M2_AXI4_AWBURST,
    output logic                      M2_AXI4_AWVALID,
    input  logic                      M2_AXI4_AWREADY,
    // AXI4 write data
    output logic [DATA_WIDTH-1:0]     M2_AXI4_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M2_AXI4_WSTRB,
    output logic                      M2_AXI4_WLAST,
    output logic                      M2_AXI4_WVALID,
    input  logic                      M2_AXI4_WREADY,
    // AXI4 write response
    input  logic [AXI4_ID_WIDTH-1:0]  M2_AXI4_BID,
    input  logic [1:0]                M2_AXI4_BRESP,
    input  logic                      M2_AXI4_BVALID,
    output logic                      M2_AXI4_BREADY,
    // AXI4 read address
    output logic [AXI4_ID_WIDTH-1:0]  M2_AXI4_ARID,
    output logic [ADDR_WIDTH-1:0]     M2_AXI4_ARADDR,
    output logic [7:0]                M2_AXI4_ARLEN,
    output logic [2:0]                M2_AXI4_ARSIZE,
    output logic [1:0]                M2_AXI4_ARBURST,
    output logic                      M2_AXI4_ARVALID,
    input  logic                      M2_AXI4_ARREADY,
    // AXI4 read data
    input  logic [AXI4_ID_WIDTH-1:0]  M2_AXI4_RID,
    input  logic [DATA_WIDTH-1:0]     M2_AXI4_RDATA,
    input  logic [1:0]                M2_AXI4_RRESP,
    input  logic                      M2_AXI4_RLAST,
    input  logic                      M2_AXI4_RVALID,
    output logic                      M2_AXI4_RREADY
);

    typedef enum logic [2:0] {
        S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
    } state_t;

    localparam logic [AXI4_ID_WIDTH-1:0] ID_ONE = 1;

    state_t                     state, state_nxt;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [DATA_WIDTH/8-1:0]    wstrb_q;
    logic [AXI4_ID_WIDTH-1:0]   id_q;      // next ID to issue
    logic [AXI4_ID_WIDTH-1:0]   iss_id_q;  // ID of the transaction in flight
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic                       err_q;
    logic                       misaligned;

    assign misaligned = (cpu_addr[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: each VALID phase waits for its handshake, no timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cpu_req) begin
                if (misaligned)  state_nxt = S_DONE;
                else if (cpu_we) state_nxt = S_AW;
                else             state_nxt = S_AR;
            end
            S_AW:   if (M2_AXI4_AWREADY) state_nxt = S_W;
            S_W:    if (M2_AXI4_WREADY)  state_nxt = S_B;
            S_B:    if (M2_AXI4_BVALID)  state_nxt = S_DONE;
            S_AR:   if (M2_AXI4_ARREADY) state_nxt = S_R;
            S_R:    if (M2_AXI4_RVALID)  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; address/data come straight from the capture registers
    always_comb begin
        M2_AXI4_AWVALID = (state == S_AW);
        M2_AXI4_WVALID  = (state == S_W);
        M2_AXI4_WLAST   = (state == S_W);
        M2_AXI4_BREADY  = (state == S_B);
        M2_AXI4_ARVALID = (state == S_AR);
        M2_AXI4_RREADY  = (state == S_R);
        cpu_done        = (state == S_DONE);
        cpu_busy        = (state != S_IDLE) && (state != S_DONE);
        cpu_err         = (state == S_DONE) && err_q;
        cpu_rdata       = rdata_q;
        M2_AXI4_AWID    = id_q;
        M2_AXI4_ARID    = id_q;
        M2_AXI4_AWADDR  = addr_q;
        M2_AXI4_ARADDR  = addr_q;
        M2_AXI4_WDATA   = wdata_q;
        M2_AXI4_WSTRB   = wstrb_q;
        M2_AXI4_AWLEN   = 8'h00;
        M2_AXI4_ARLEN   = 8'h00;
        M2_AXI4_AWSIZE  = 3'b010;
        M2_AXI4_ARSIZE  = 3'b010;
        M2_AXI4_AWBURST = 2'b01;
        M2_AXI4_ARBURST = 2'b01;
    end

    // Request capture, ID counter and response checking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            id_q     <= '0;
            iss_id_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cpu_req) begin
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                    wstrb_q <= cpu_wstrb;
                    // misaligned requests skip the bus and leave the ID untouched
                    err_q   <= misaligned;
                end
                S_AW: if (M2_AXI4_AWREADY) begin
                    iss_id_q <= id_q;
                    id_q     <= id_q + ID_ONE;
                end
                S_AR: if (M2_AXI4_ARREADY) begin
                    iss_id_q <= id_q;
                    id_q     <= id_q + ID_ONE;
                end
                S_B: if (M2_AXI4_BVALID)
                    err_q <= (M2_AXI4_BRESP != 2'b00) || (M2_AXI4_BID != iss_id_q);
                S_R: if (M2_AXI4_RVALID) begin
                    rdata_q <= M2_AXI4_RDATA;
                    err_q   <= (M2_AXI4_RRESP != 2'b00) || (M2_AXI4_RID != iss_id_q)
                               || !M2_AXI4_RLAST;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem2axi4_bridge.sv
// Directed bench for mem2axi4_bridge: AXI4 slave stub over a small word
// memory, CPU requests issued in sequence, expected results queued at issue
// and compared when cpu_done arrives.
module tb_mem2axi4_bridge;
    localparam int IW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_wstrb = '0;
    logic        cpu_busy, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;

    logic [IW-1:0] awid, arid, bid, rid;
    logic [31:0]   awaddr, araddr, wdata, rdata;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic          arvalid, arready, rvalid, rready, rlast;
    logic [3:0]    wstrb;

    always #5 clk = ~clk;

    mem2axi4_bridge #(.AXI4_ID_WIDTH(IW), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .M2_AXI4_AWID(awid), .M2_AXI4_AWADDR(awaddr), .M2_AXI4_AWLEN(awlen),
        .M2_AXI4_AWSIZE(awsize), .M2_AXI4_AWBURST(awburst), .M2_AXI4_AWVALID(awvalid),
        .M2_AXI4_AWREADY(awready),
        .M2_AXI4_WDATA(wdata), .M2_AXI4_WSTRB(wstrb), .M2_AXI4_WLAST(wlast),
        .M2_AXI4_WVALID(wvalid), .M2_AXI4_WREADY(wready),
        .M2_AXI4_BID(bid), .M2_AXI4_BRESP(bresp), .M2_AXI4_BVALID(bvalid),
        .M2_AXI4_BREADY(bready),
        .M2_AXI4_ARID(arid), .M2_AXI4_ARADDR(araddr), .M2_AXI4_ARLEN(arlen),
        .M2_AXI4_ARSIZE(arsize), .M2_AXI4_ARBURST(arburst), .M2_AXI4_ARVALID(arvalid),
        .M2_AXI4_ARREADY(arready),
        .M2_AXI4_RID(rid), .M2_AXI4_RDATA(rdata), .M2_AXI4_RRESP(rresp),
        .M2_AXI4_RLAST(rlast), .M2_AXI4_RVALID(rvalid), .M2_AXI4_RREADY(rready)
    );

    // ---------------- slave stub ----------------
    logic [31:0]   mem [0:63];
    logic          mem_ready = 1'b0;
    logic [IW-1:0] bid_xor = '0;
    logic [1:0]    rresp_cfg = 2'b00;
    logic          rlast_cfg = 1'b1;
    int            ar_wait_cfg = 0, b_wait_cfg = 0;

    int            ar_wait, b_wait, ar_vld_cycles;
    logic          b_pend, aw_seen, w_order_ok, last_wlast;
    logic [31:0]   aw_addr_q;
    logic [IW-1:0] aw_id_q, last_awid, last_arid;
    logic [7:0]    last_awlen;
    logic [2:0]    last_awsize;
    logic [1:0]    last_awburst;

    assign awready = 1'b1;
    assign wready  = 1'b1;
    assign arready = (ar_wait == 0);

    // memory: preload once, then byte-strobed writes at the latched AW address
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h11111111;
            mem_ready <= 1'b1;
        end else if (wvalid && wready) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[aw_addr_q[7:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // channel handshakes, response generation and bus monitors
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_wait <= 0; b_wait <= 0; b_pend <= 1'b0; ar_vld_cycles <= 0;
            aw_seen <= 1'b0; w_order_ok <= 1'b0; last_wlast <= 1'b0;
            aw_addr_q <= '0; aw_id_q <= '0; last_awid <= '0; last_arid <= '0;
            last_awlen <= '1; last_awsize <= '0; last_awburst <= '0;
            bvalid <= 1'b0; bid <= '0; bresp <= '0;
            rvalid <= 1'b0; rid <= '0; rdata <= '0; rresp <= '0; rlast <= 1'b0;
        end else begin
            if (!arvalid)         ar_wait <= ar_wait_cfg;
            else if (ar_wait != 0) ar_wait <= ar_wait - 1;
            if (arvalid) ar_vld_cycles <= ar_vld_cycles + 1;
            if (awvalid && awready) begin
                aw_addr_q <= awaddr; aw_id_q <= awid; aw_seen <= 1'b1;
                last_awid <= awid; last_awlen <= awlen;
                last_awsize <= awsize; last_awburst <= awburst;
            end
            if (wvalid && wready) begin
                w_order_ok <= aw_seen; aw_seen <= 1'b0; last_wlast <= wlast;
                bid <= aw_id_q ^ bid_xor; bresp <= 2'b00;
                if (b_wait_cfg == 0) bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_wait <= b_wait_cfg - 1; end
            end
            if (b_pend) begin
                if (b_wait == 0) begin bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_wait <= b_wait - 1;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rdata <= mem[araddr[7:2]]; rid <= arid;
                rresp <= rresp_cfg; rlast <= rlast_cfg; last_arid <= arid;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    exp_t          sb[$];
    logic [31:0]   ref_mem [0:63];
    int            vectors = 0, miscompares = 0;
    logic [IW-1:0] exp_id = '0;
    bit            ar_hold_chk = 0;
    int            n_ar;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one request, queue its expectation, wait for done and compare
    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input int lat, input logic exp_err,
                       input logic chk_rd);
        exp_t e;
        int   cyc;
        bit   done;
        e.rdata = ref_mem[addr[7:2]];
        e.err = exp_err;
        e.chk_rd = chk_rd;
        if (we && addr[1:0] == 2'b00)
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[7:2]][8*b +: 8] = wd[8*b +: 8];
        sb.push_back(e);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_wstrb = strb;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        cyc = 0; done = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && lat > 1) chk("busy_after_accept", cpu_busy, 1);
            if (ar_hold_chk && cyc <= 6) begin
                chk("arvalid_held", arvalid, 1);
                chk("araddr_held", araddr, addr);
            end
            if (cpu_done) done = 1;
        end
        e = sb.pop_front();
        chk("done_seen", done, 1);
        if (done) begin
            chk("latency", cyc, lat);
            chk("err", cpu_err, e.err);
            chk("busy_at_done", cpu_busy, 0);
            if (e.chk_rd) chk("rdata", cpu_rdata, e.rdata);
        end
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h11111111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // reset state
        chk("rst_busy", cpu_busy, 0);   chk("rst_done", cpu_done, 0);
        chk("rst_err", cpu_err, 0);     chk("rst_rdata", cpu_rdata, 0);
        chk("rst_awvalid", awvalid, 0); chk("rst_arvalid", arvalid, 0);
        chk("rst_wvalid", wvalid, 0);   chk("rst_bready", bready, 0);
        chk("rst_rready", rready, 0);   chk("rst_wlast", wlast, 0);
        chk("rst_awaddr", awaddr, 0);   chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);     chk("rst_awid", awid, 0);
        rst_n = 1'b1;

        // preloaded reads, IDs 0..2
        req(0, 32'h00, 0, 0, 3, 0, 1); chk("arid0", last_arid, exp_id); exp_id++;
        req(0, 32'h04, 0, 0, 3, 0, 1); chk("arid1", last_arid, exp_id); exp_id++;
        req(0, 32'h14, 0, 0, 3, 0, 1); chk("arid2", last_arid, exp_id); exp_id++;

        // full write then read back
        req(1, 32'h20, 32'hDEADBEEF, 4'hF, 4, 0, 0);
        chk("awid", last_awid, exp_id); exp_id++;
        chk("aw_before_w", w_order_ok, 1); chk("wlast", last_wlast, 1);
        chk("awlen", last_awlen, 0); chk("awsize", last_awsize, 3'b010);
        chk("awburst", last_awburst, 2'b01);
        req(0, 32'h20, 0, 0, 3, 0, 1); exp_id++;

        // partial-strobe write merges with the old word
        req(1, 32'h24, 32'hCAFEBABE, 4'b0011, 4, 0, 0); exp_id++;
        req(0, 32'h24, 0, 0, 3, 0, 1); exp_id++;

        // misaligned: immediate error, no AR traffic, ID not consumed
        n_ar = ar_vld_cycles;
        req(0, 32'h22, 0, 0, 1, 1, 0);
        chk("no_arvalid", ar_vld_cycles, n_ar);
        req(0, 32'h08, 0, 0, 3, 0, 1); chk("arid_unconsumed", last_arid, exp_id); exp_id++;

        // slave-side error responses
        rresp_cfg = 2'b10;
        req(0, 32'h0C, 0, 0, 3, 1, 0); exp_id++;
        rresp_cfg = 2'b00; bid_xor = 4'h1;
        req(1, 32'h28, 32'h12345678, 4'hF, 4, 1, 0); exp_id++;
        bid_xor = '0; rlast_cfg = 1'b0;
        req(0, 32'h10, 0, 0, 3, 1, 0); exp_id++;
        rlast_cfg = 1'b1;

        // ARREADY held low for 5 cycles
        ar_wait_cfg = 5; ar_hold_chk = 1;
        req(0, 32'h18, 0, 0, 8, 0, 1); chk("arid_hold", last_arid, exp_id); exp_id++;
        ar_wait_cfg = 0; ar_hold_chk = 0;

        // reset while waiting in B
        b_wait_cfg = 4;
        for (int b = 0; b < 4; b++) ref_mem[12][8*b +: 8] = 8'(32'hAAAA5555 >> (8*b));
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA5555; cpu_wstrb = 4'hF;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        cyc = 0;
        while (!bready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("reached_b", bready, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bready", bready, 0); chk("mid_rst_busy", cpu_busy, 0);
        chk("mid_rst_awaddr", awaddr, 0); chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_wstrb", wstrb, 0);   chk("mid_rst_awid", awid, 0);
        chk("mid_rst_rdata", cpu_rdata, 0); chk("mid_rst_wlast", wlast, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; b_wait_cfg = 0; exp_id = '0;
        req(0, 32'h04, 0, 0, 3, 0, 1); chk("arid_after_rst", last_arid, exp_id);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem2axi4_bridge.md
# mem2axi4_bridge

Single-outstanding bridge from the CPU core's native load/store port to the AXI4 slave port (M2_AXI4_*) of dram_controller. Each CPU request becomes exactly one single-beat AXI4 transaction: write via AW, then W, then B; read via AR, then R. The bridge checks the response and returns read data or an error flag to the core with a one-cycle done pulse.

## Interface
- AXI4_ID_WIDTH, 4, width of AWID/ARID/BID/RID
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; fixed at 32 in this revision, so AxSIZE = 3'b010
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  request; sampled only in IDLE
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  byte address; must be word aligned
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_wstrb  in  DATA_WIDTH/8  byte strobes
- cpu_busy  out  1  high from the acceptance cycle until the done pulse
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data; valid with cpu_done on reads, held until the next done
- cpu_err  out  1  valid with cpu_done
- M2_AXI4_AW*: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in)
- M2_AXI4_W*: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in)
- M2_AXI4_B*: BID, BRESP, BVALID (in); BREADY (out)
- M2_AXI4_AR*: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (out); ARREADY (in)
- M2_AXI4_R*: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out)

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE, cpu_req=1:
  - Capture addr, wdata, wstrb and we into registers.
  - Set cpu_busy.
  - If addr[1:0]≠0, go to DONE with err=1; no AXI traffic is issued and the ID is not consumed.
  - Otherwise go to AW if we=1, or AR if we=0.
- AW: AWVALID=1 with AWADDR/AWID held stable. On AWVALID&AWREADY, go to W.
- W: WVALID=1, WLAST=1. On WREADY, go to B.
- B: BREADY=1. On BVALID, go to DONE. err = (BRESP≠2'b00) | (BID≠issued ID).
- AR: ARVALID=1. On ARREADY, go to R.
- R: RREADY=1. On RVALID:
  - Capture RDATA into cpu_rdata.
  - err = (RRESP≠2'b00) | (RID≠issued ID) | ~RLAST.
  - Go to DONE.
- DONE: cpu_done=1 for one cycle, cpu_busy=0, then return to IDLE.
- Constant fields: AxLEN=8'h00, AxSIZE=3'b010, AxBURST=2'b01 (INCR).
- ID counter:
  - Width AXI4_ID_WIDTH, resets to 0.
  - Incremented on every AW or AR handshake; wraps modulo 2^AXI4_ID_WIDTH.
  - The issued ID is the counter value at the time AWVALID or ARVALID is first asserted.
- A VALID, once asserted, is never dropped before its READY; the bridge never abandons a transaction.
- cpu_req asserted during busy or DONE is ignored; the core must hold it or reissue it.

## Timing
- Reset (asynchronous): state=IDLE, id=0. All outputs 0:
  - all *VALID, BREADY, RREADY, WLAST
  - cpu_busy, cpu_done, cpu_err, cpu_rdata
  - AxADDR, WDATA, WSTRB, AxID
- Reset asserted mid-transaction: outputs clear immediately. Any in-flight downstream transaction is lost; the system resets dram_controller together with the bridge.
- Write, acceptance at cycle N with zero-wait slave:
  - AWVALID at N+1
  - WVALID at N+2
  - BREADY at N+3
  - BVALID seen at N+3 gives cpu_done at N+4
- Read, zero-wait slave: ARVALID at N+1, RREADY at N+2, cpu_done at N+3.
- Misaligned request: cpu_done with cpu_err=1 at N+1.
- Earliest next acceptance: the cycle after cpu_done.
- Any slave wait states add cycle-for-cycle latency; there is no timeout.
- READY may already be high when VALID rises; the handshake then completes in the VALID cycle.

## Test plan
- Preloaded dummy DRAM (word i = i*0x11111111). Read 0x00, 0x04, 0x14 → cpu_rdata 00000000, 11111111, 55555555; cpu_err=0; ARID 0, 1, 2.
- Write 0x20=DEADBEEF with wstrb=F, then read 0x20 → done with err=0, then rdata DEADBEEF. Check AW precedes W, WLAST=1, AWLEN=0, AWSIZE=2.
- Write 0x24=CAFEBABE with wstrb=4'b0011 over a known old value → read returns old[31:16] combined with BABE.
- Read address 0x22 → cpu_done with err=1 one cycle after acceptance; no ARVALID ever; the next legal read uses the unconsumed ID.
- Slave stub returns RRESP=2'b10, or BID mismatch, or RLAST=0 → cpu_err=1. Stub holds ARREADY low for 5 cycles → ARVALID stays high and stable throughout.
- Assert rst_n=0 while in B → all outputs 0 the same cycle; after release, a read of 0x04 returns 11111111 with ARID=0.
